fft_frame_sched: RTL and testbench

//  Frame scheduler for the cascade_n FFT chain. Packs a streaming complex input into a ping-pong

---
 rtl/fft_frame_sched.sv | 259 +++++++++++++++++++++++++
 tb/tb_fft_frame_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sched.sv
// fft_frame_sched: frame scheduler for the cascade_n FFT chain.
// Packs a streaming complex input into a ping-pong frame buffer served to stage 1
// over the sink_* read handshake, and sweeps the last stage's source_* port to emit
// a framed output stream. Keeps frame counts and a sticky overrun flag.
// Handshakes: an input sample transfers on a cycle where in_valid and in_ready are
// both high; a frame is handed to stage 1 while sink_ready is high and released by
// sink_rdack; a last-stage frame is claimed on source_ready and released by the
// one-cycle source_rdack pulse.
// Build option: define FFT_SCHED_BITREV_EN to sweep source addresses in bit-reversed
// order (natural frequency order at the output); otherwise stage order is used.
module fft_frame_sched #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 20,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         aclr_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_Re,
  input  logic signed [DATA_WIDTH-1:0] in_Im,
  output logic                         sink_ready,
  input  logic [ADDR_WIDTH-1:0]        sink_rdaddr,
  output logic signed [DATA_WIDTH-1:0] sink_Re,
  output logic signed [DATA_WIDTH-1:0] sink_Im,
  input  logic                         sink_rdack,
  output logic [ADDR_WIDTH-1:0]        source_rdaddr,
  input  logic                         source_ready,
  output logic                         source_rdack,
  input  logic signed [OUT_WIDTH-1:0]  source_Re,
  input  logic signed [OUT_WIDTH-1:0]  source_Im,
  output logic                         out_valid,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic signed [OUT_WIDTH-1:0]  out_Re,
  output logic signed [OUT_WIDTH-1:0]  out_Im,
  output logic [CNT_WIDTH-1:0]         frames_in,
  output logic [CNT_WIDTH-1:0]         frames_out,
  output logic                         overrun,
  input  logic                         clr_stat,
  output logic [1:0]                   dbg_out_state
);

  localparam int N = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic [1:0] {BUF_EMPTY = 2'd0, BUF_FILLING = 2'd1, BUF_FULL = 2'd2} buf_state_e;
  typedef enum logic [1:0] {OUT_IDLE = 2'd0, OUT_READ = 2'd1, OUT_ACK = 2'd2} out_state_e;

  // Frame storage: buffer index is the address MSB
  logic [DATA_WIDTH-1:0] mem_re [0:2*N-1];
  logic [DATA_WIDTH-1:0] mem_im [0:2*N-1];

  buf_state_e            buf_q [2];
  buf_state_e            buf_d [2];
  logic                  wr_buf_q, wr_buf_d;
  logic                  rd_buf_q, rd_buf_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic                  sink_ready_q, sink_ready_d;
  logic [DATA_WIDTH-1:0] sink_re_q, sink_im_q;
  logic                  wr_en;
  logic                  frame_in_done;

  out_state_e            out_state_q, out_state_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;
  logic                  frame_out_done;

  logic [CNT_WIDTH-1:0]  frames_in_q, frames_in_d;
  logic [CNT_WIDTH-1:0]  frames_out_q, frames_out_d;
  logic                  overrun_q, overrun_d;

  // Source sweep address order
  function automatic logic [ADDR_WIDTH-1:0] addr_map(input logic [ADDR_WIDTH-1:0] c);
    logic [ADDR_WIDTH-1:0] r;
`ifdef FFT_SCHED_BITREV_EN
    for (int i = 0; i < ADDR_WIDTH; i++) r[i] = c[ADDR_WIDTH-1-i];
`else
    r = c;
`endif
    return r;
  endfunction

  // in_ready is held low while reset is asserted so every output reads 0 in reset
  assign in_ready = aclr_n & (buf_q[wr_buf_q] != BUF_FULL);
  assign wr_en    = in_valid & in_ready & ~flush;

  // Sample write into the buffer being filled
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re[{wr_buf_q, wr_cnt_q}] <= in_Re;
      mem_im[{wr_buf_q, wr_cnt_q}] <= in_Im;
    end
  end

  // Ping-pong buffer bookkeeping; release and final write never target the same buffer
  always_comb begin
    buf_d[0]      = buf_q[0];
    buf_d[1]      = buf_q[1];
    wr_buf_d      = wr_buf_q;
    rd_buf_d      = rd_buf_q;
    wr_cnt_d      = wr_cnt_q;
    frame_in_done = 1'b0;
    if (flush) begin
      buf_d[0] = BUF_EMPTY;
      buf_d[1] = BUF_EMPTY;
      wr_buf_d = 1'b0;
      rd_buf_d = 1'b0;
      wr_cnt_d = '0;
    end else begin
      if (sink_rdack && sink_ready_q) begin
        buf_d[rd_buf_q] = BUF_EMPTY;
        rd_buf_d        = ~rd_buf_q;
      end
      if (wr_en) begin
        if (wr_cnt_q == LAST) begin
          buf_d[wr_buf_q] = BUF_FULL;
          wr_buf_d        = ~wr_buf_q;
          wr_cnt_d        = '0;
          frame_in_done   = 1'b1;
        end else begin
          buf_d[wr_buf_q] = BUF_FILLING;
          wr_cnt_d        = wr_cnt_q + ADDR_WIDTH'(1);
        end
      end
    end
    sink_ready_d = (buf_d[rd_buf_d] == BUF_FULL);
  end

  // Input-side state registers and registered stage-1 read port
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      buf_q[0]     <= BUF_EMPTY;
      buf_q[1]     <= BUF_EMPTY;
      wr_buf_q     <= 1'b0;
      rd_buf_q     <= 1'b0;
      wr_cnt_q     <= '0;
      sink_ready_q <= 1'b0;
      sink_re_q    <= '0;
      sink_im_q    <= '0;
    end else begin
      buf_q[0]     <= buf_d[0];
      buf_q[1]     <= buf_d[1];
      wr_buf_q     <= wr_buf_d;
      rd_buf_q     <= rd_buf_d;
      wr_cnt_q     <= wr_cnt_d;
      sink_ready_q <= sink_ready_d;
      sink_re_q    <= mem_re[{rd_buf_q, sink_rdaddr}];
      sink_im_q    <= mem_im[{rd_buf_q, sink_rdaddr}];
    end
  end

  // Output FSM next state: claim a frame, sweep N addresses, acknowledge
  always_comb begin
    out_state_d    = out_state_q;
    rd_cnt_d       = rd_cnt_q;
    out_valid_d    = 1'b0;
    out_sop_d      = 1'b0;
    out_eop_d      = 1'b0;
    frame_out_done = 1'b0;
    if (flush) begin
      out_state_d = OUT_IDLE;
      rd_cnt_d    = '0;
    end else begin
      case (out_state_q)
        OUT_IDLE: begin
          if (source_ready) begin
            out_state_d = OUT_READ;
            rd_cnt_d    = '0;
          end
        end
        OUT_READ: begin
          out_valid_d = 1'b1;
          out_sop_d   = (rd_cnt_q == '0);
          out_eop_d   = (rd_cnt_q == LAST);
          if (rd_cnt_q == LAST) begin
            out_state_d = OUT_ACK;
            rd_cnt_d    = '0;
          end else begin
            rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
          end
        end
        OUT_ACK: begin
          frame_out_done = 1'b1;
          out_state_d    = OUT_IDLE;
        end
        default: out_state_d = OUT_IDLE;
      endcase
    end
  end

  // Output FSM state register and stream qualifiers (one cycle behind the address)
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      out_state_q <= OUT_IDLE;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      out_state_q <= out_state_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

  // Statistics: clear wins over a coincident increment; flush leaves them untouched
  always_comb begin
    frames_in_d  = frames_in_q;
    frames_out_d = frames_out_q;
    overrun_d    = overrun_q;
    if (!flush) begin
      if (clr_stat) begin
        frames_in_d  = '0;
        frames_out_d = '0;
        overrun_d    = 1'b0;
      end else begin
        if (frame_in_done)  frames_in_d  = frames_in_q + CNT_WIDTH'(1);
        if (frame_out_done) frames_out_d = frames_out_q + CNT_WIDTH'(1);
        if (in_valid && !in_ready) overrun_d = 1'b1;
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      frames_in_q  <= '0;
      frames_out_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      frames_in_q  <= frames_in_d;
      frames_out_q <= frames_out_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sink_ready    = sink_ready_q;
  assign sink_Re       = sink_re_q;
  assign sink_Im       = sink_im_q;
  assign source_rdaddr = (out_state_q == OUT_READ) ? addr_map(rd_cnt_q) : '0;
  assign source_rdack  = (out_state_q == OUT_ACK) & ~flush;
  assign out_valid     = out_valid_q;
  assign out_sop       = out_sop_q;
  assign out_eop       = out_eop_q;
  assign out_Re        = out_valid_q ? source_Re : '0;
  assign out_Im        = out_valid_q ? source_Im : '0;
  assign frames_in     = frames_in_q;
  assign frames_out    = frames_out_q;
  assign overrun       = overrun_q;
  assign dbg_out_state = out_state_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched: input packing, stage-1 reads, overrun,
// output sweep, simultaneous final-write/release, flush and async reset.
module tb_fft_frame_sched;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int OW = 20;
  localparam int CW = 16;
  localparam int N  = 512;

  logic                 clk = 1'b0;
  logic                 aclr_n, flush, in_valid, in_ready;
  logic signed [DW-1:0] in_Re, in_Im;
  logic                 sink_ready, sink_rdack;
  logic [AW-1:0]        sink_rdaddr;
  logic signed [DW-1:0] sink_Re, sink_Im;
  logic [AW-1:0]        source_rdaddr;
  logic                 source_ready, source_rdack;
  logic signed [OW-1:0] source_Re, source_Im;
  logic                 out_valid, out_sop, out_eop;
  logic signed [OW-1:0] out_Re, out_Im;
  logic [CW-1:0]        frames_in, frames_out;
  logic                 overrun, clr_stat;
  logic [1:0]           dbg_out_state;

  int checks = 0;
  int failures = 0;

  fft_frame_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .aclr_n(aclr_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_Re(in_Re), .in_Im(in_Im),
    .sink_ready(sink_ready), .sink_rdaddr(sink_rdaddr), .sink_Re(sink_Re), .sink_Im(sink_Im),
    .sink_rdack(sink_rdack),
    .source_rdaddr(source_rdaddr), .source_ready(source_ready), .source_rdack(source_rdack),
    .source_Re(source_Re), .source_Im(source_Im),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_Re(out_Re), .out_Im(out_Im),
    .frames_in(frames_in), .frames_out(frames_out), .overrun(overrun), .clr_stat(clr_stat),
    .dbg_out_state(dbg_out_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Last-stage stub: data valid one cycle after the address
  logic [AW-1:0] src_addr_d = '0;
  always @(posedge clk) src_addr_d <= source_rdaddr;
  assign source_Re = OW'(32'(src_addr_d) * 3 + 7);
  assign source_Im = OW'(32'd900000 - 32'(src_addr_d));

  function automatic logic [DW-1:0] pat_re(input int f, input int k);
    return DW'(f * 1000 + k);
  endfunction

  function automatic logic [DW-1:0] pat_im(input int f, input int k);
    return DW'(f * 37 - 3 * k);
  endfunction

  function automatic int exp_map(input int c);
    int r;
`ifdef FFT_SCHED_BITREV_EN
    r = 0;
    for (int i = 0; i < AW; i++) if (c[i]) r = r | (1 << (AW - 1 - i));
`else
    r = c;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push nsamp samples of frame f; optionally pulse sink_rdack / clr_stat on the last one
  task automatic push_frame(input int f, input int nsamp, input bit ack_last, input bit clr_last);
    int bad;
    bad = 0;
    for (int k = 0; k < nsamp; k++) begin
      in_valid = 1'b1;
      in_Re    = pat_re(f, k);
      in_Im    = pat_im(f, k);
      if (k == nsamp - 1) begin
        sink_rdack = ack_last;
        clr_stat   = clr_last;
      end
      #1;
      if (in_ready !== 1'b1) bad++;
      tick();
    end
    in_valid   = 1'b0;
    sink_rdack = 1'b0;
    clr_stat   = 1'b0;
    check("push_in_ready", 32'(bad), 32'd0);
  endtask

  // Stage-1 model: read addresses 0..N-1, compare with frame f, optionally release
  task automatic read_frame(input int f, input bit ack, input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < N; a++) begin
      sink_rdaddr = AW'(a);
      tick();
      if (sink_Re !== pat_re(f, a) || sink_Im !== pat_im(f, a)) bad++;
    end
    check(tag, 32'(bad), 32'd0);
    if (ack) begin
      sink_rdack = 1'b1;
      tick();
      sink_rdack = 1'b0;
    end
  endtask

  // Full output sweep starting from IDLE, checked cycle by cycle
  task automatic sweep_output();
    int bad_addr, bad_valid, bad_sop, bad_eop, bad_data, ack_cnt;
    logic [OW-1:0] er, ei;
    bad_addr = 0; bad_valid = 0; bad_sop = 0; bad_eop = 0; bad_data = 0; ack_cnt = 0;
    source_ready = 1'b1;
    tick();
    source_ready = 1'b0;
    for (int t = 0; t <= N + 2; t++) begin
      if (t < N && source_rdaddr !== AW'(exp_map(t))) bad_addr++;
      if (out_valid !== (t >= 1 && t <= N)) bad_valid++;
      if (out_sop !== (t == 1)) bad_sop++;
      if (out_eop !== (t == N)) bad_eop++;
      if (t >= 1 && t <= N) begin
        er = OW'(exp_map(t - 1) * 3 + 7);
        ei = OW'(900000 - exp_map(t - 1));
        if (out_Re !== er || out_Im !== ei) bad_data++;
      end
      if (source_rdack === 1'b1) begin
        ack_cnt++;
        if (t != N) bad_valid++;
      end
      tick();
    end
    check("t4_rdaddr_seq", 32'(bad_addr), 32'd0);
    check("t4_out_valid", 32'(bad_valid), 32'd0);
    check("t4_out_sop", 32'(bad_sop), 32'd0);
    check("t4_out_eop", 32'(bad_eop), 32'd0);
    check("t4_out_data", 32'(bad_data), 32'd0);
    check("t4_rdack_pulses", 32'(ack_cnt), 32'd1);
    check("t4_frames_out", 32'(frames_out), 32'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int eop_cnt, vld_cnt;
    aclr_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_Re = '0; in_Im = '0;
    sink_rdaddr = '0; sink_rdack = 1'b0; source_ready = 1'b0; clr_stat = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_sink_ready", 32'(sink_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_frames_in", 32'(frames_in), 32'd0);
    check("rst_frames_out", 32'(frames_out), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_fsm_idle", 32'(dbg_out_state), 32'd0);
    aclr_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1: one full frame
    push_frame(0, N, 1'b0, 1'b0);
    check("t1_sink_ready", 32'(sink_ready), 32'd1);
    check("t1_frames_in", 32'(frames_in), 32'd1);

    // 2: stage-1 read and release
    read_frame(0, 1'b1, "t2_sink_data");
    check("t2_sink_ready_low", 32'(sink_ready), 32'd0);
    check("t2_in_ready", 32'(in_ready), 32'd1);

    // 3: fill both buffers, then overrun
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    check("t3_clr_frames_in", 32'(frames_in), 32'd0);
    push_frame(1, N, 1'b0, 1'b0);
    push_frame(2, N, 1'b0, 1'b0);
    check("t3_in_ready_low", 32'(in_ready), 32'd0);
    check("t3_frames_in", 32'(frames_in), 32'd2);
    check("t3_no_overrun_yet", 32'(overrun), 32'd0);
    in_valid = 1'b1;
    in_Re    = pat_re(3, 0);
    in_Im    = pat_im(3, 0);
    tick();
    in_valid = 1'b0;
    check("t3_overrun", 32'(overrun), 32'd1);
    check("t3_frames_in_hold", 32'(frames_in), 32'd2);

    // 5: release with the other buffer full, then final write + release together
    read_frame(1, 1'b1, "t5_frame1_data");
    check("t5_sink_ready_other_full", 32'(sink_ready), 32'd1);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    push_frame(3, N, 1'b1, 1'b0);
    check("t5_sink_ready_same_cycle", 32'(sink_ready), 32'd1);
    check("t5_frames_in", 32'(frames_in), 32'd3);
    read_frame(3, 1'b1, "t5_other_buf_data");
    check("t5_sink_ready_drained", 32'(sink_ready), 32'd0);

    // 4: output sweep
    sweep_output();

    // 6: flush mid-fill with one frame buffered
    push_frame(4, N, 1'b0, 1'b0);
    push_frame(5, 100, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_flush_in_ready", 32'(in_ready), 32'd1);
    check("t6_flush_sink_ready", 32'(sink_ready), 32'd0);
    check("t6_flush_frames_in", 32'(frames_in), 32'd4);
    check("t6_flush_overrun_kept", 32'(overrun), 32'd1);
    // Refill from address 0 of buffer 0; clr_stat coincides with the frame increment
    push_frame(6, N, 1'b0, 1'b1);
    check("t6_clr_vs_incr", 32'(frames_in), 32'd0);
    check("t6_clr_overrun", 32'(overrun), 32'd0);
    check("t6_refill_ready", 32'(sink_ready), 32'd1);
    read_frame(6, 1'b1, "t6_refill_data");

    // 6: flush mid-READ truncates the frame
    source_ready = 1'b1;
    tick();
    source_ready = 1'b0;
    repeat (50) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_read_flush_idle", 32'(dbg_out_state), 32'd0);
    check("t6_read_flush_valid", 32'(out_valid), 32'd0);
    check("t6_read_flush_rdack", 32'(source_rdack), 32'd0);
    check("t6_read_flush_frames_out", 32'(frames_out), 32'd0);
    eop_cnt = 0;
    vld_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_eop === 1'b1) eop_cnt++;
      if (out_valid === 1'b1) vld_cnt++;
      tick();
    end
    check("t6_no_eop_after_flush", 32'(eop_cnt), 32'd0);
    check("t6_no_valid_after_flush", 32'(vld_cnt), 32'd0);

    // 6: asynchronous reset mid-frame
    source_ready = 1'b1;
    tick();
    source_ready = 1'b0;
    repeat (5) tick();
    in_valid = 1'b1;
    in_Re    = pat_re(7, 0);
    in_Im    = pat_im(7, 0);
    tick();
    check("pre_areset_out_valid", 32'(out_valid), 32'd1);
    #2;
    aclr_n = 1'b0;
    #1;
    check("areset_in_ready", 32'(in_ready), 32'd0);
    check("areset_source_rdaddr", 32'(source_rdaddr), 32'd0);
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_out_re", 32'(out_Re), 32'd0);
    check("areset_sink_re", 32'(sink_Re), 32'd0);
    check("areset_fsm_idle", 32'(dbg_out_state), 32'd0);
    in_valid = 1'b0;
    tick();
    aclr_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
